// File: rtl/osc_bank_sched.sv
// osc_bank_sched: time-multiplexed oscillator bank sharing one saw2sin converter.
// On each accepted frame tick every voice's 16-bit phase is issued to the
// converter back to back, accumulated by its increment, and one tagged sine
// sample per voice is returned two cycles after issue.
// Optional feature: define OSC_SCHED_MUTE_EN to add the per-voice i_mute port.
module osc_bank_sched #(
    parameter  int VOICES = 4,
    localparam int IW     = $clog2(VOICES)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic              i_cfg_we,
    input  logic [IW-1:0]     i_cfg_addr,
    input  logic [15:0]       i_cfg_inc,
    input  logic              i_cfg_zero,
    output logic [15:0]       o_saw,
    input  logic [15:0]       i_sin,
    output logic [15:0]       o_sample,
    output logic [IW-1:0]     o_voice,
    output logic              o_valid,
    output logic              o_busy,
`ifdef OSC_SCHED_MUTE_EN
    input  logic [VOICES-1:0] i_mute,
`endif
    input  logic              i_ovr_clr,
    output logic              o_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [15:0]   phase [VOICES];
    logic [15:0]   inc   [VOICES];
    logic [15:0]   saw_hold;
    logic          s1_valid;
    logic [IW-1:0] s1_idx;
    logic          tick_ok;
    logic          cfg_hit;
    logic [15:0]   sample_in;

    // A frame is in flight while issuing or while either pipeline stage holds data.
    assign o_busy  = (state == ISSUE) | s1_valid | o_valid;
    assign tick_ok = i_tick & ~o_busy;
    assign cfg_hit = i_cfg_we & (int'(i_cfg_addr) < VOICES);

    // The converter sees the live phase while issuing and the last issued phase otherwise.
    assign o_saw = (state == ISSUE) ? phase[idx] : saw_hold;

`ifdef OSC_SCHED_MUTE_EN
    assign sample_in = i_mute[s1_idx] ? 16'h0000 : i_sin;
`else
    assign sample_in = i_sin;
`endif

    // State and voice-counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic: walk the voice counter once per accepted tick.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (tick_ok) begin
                    state_nx = ISSUE;
                    idx_nx   = '0;
                end
            end
            ISSUE: begin
                if (idx == IW'(VOICES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Per-voice phase accumulation and configuration writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: this small register file is reset because phases and increments
        // must start at zero; large RAM-style arrays would normally be left unreset.
        if (!i_rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                // The issue uses the increment held before any same-cycle write.
                if ((state == ISSUE) && (idx == IW'(v))) begin
                    phase[v] <= phase[v] + inc[v];
                end
                // Zeroing is written last so it wins over a simultaneous accumulate.
                if (cfg_hit && (i_cfg_addr == IW'(v))) begin
                    inc[v] <= i_cfg_inc;
                    if (i_cfg_zero) begin
                        phase[v] <= '0;
                    end
                end
            end
        end
    end

    // Hold the last issued phase so o_saw is stable between frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            saw_hold <= '0;
        end else if (state == ISSUE) begin
            saw_hold <= phase[idx];
        end
    end

    // Two-stage valid/index pipeline aligned with the converter latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            o_valid  <= 1'b0;
            o_voice  <= '0;
            o_sample <= '0;
        end else begin
            s1_valid <= (state == ISSUE);
            s1_idx   <= idx;
            o_valid  <= s1_valid;
            if (s1_valid) begin
                o_voice  <= s1_idx;
                o_sample <= sample_in;
            end
        end
    end

    // Sticky overrun flag; a dropped tick outranks a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (i_tick && o_busy) begin
            o_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osc_bank_sched.sv
// tb_osc_bank_sched: directed bench for osc_bank_sched with a stand-in saw2sin
// model and scoreboard queues filled at each frame tick.
// Build with OSC_SCHED_MUTE_EN defined to also exercise the mute port.
module tb_osc_bank_sched;

    localparam int VOICES = 4;
    localparam int IW     = 2;

    typedef struct packed {
        logic [IW-1:0] voice;
        logic [15:0]   sample;
    } smp_t;

    logic              i_clk      = 1'b0;
    logic              i_rst_n    = 1'b0;
    logic              i_tick     = 1'b0;
    logic              i_cfg_we   = 1'b0;
    logic [IW-1:0]     i_cfg_addr = '0;
    logic [15:0]       i_cfg_inc  = '0;
    logic              i_cfg_zero = 1'b0;
    logic              i_ovr_clr  = 1'b0;
    logic [15:0]       i_sin;
    logic [15:0]       o_saw;
    logic [15:0]       o_sample;
    logic [IW-1:0]     o_voice;
    logic              o_valid;
    logic              o_busy;
    logic              o_overrun;
`ifdef OSC_SCHED_MUTE_EN
    logic [VOICES-1:0] i_mute     = '0;
`endif

    int checks   = 0;
    int failures = 0;

    // Bench-side model state.
    logic [15:0]       m_phase [VOICES];
    logic [15:0]       m_inc   [VOICES];
    logic [VOICES-1:0] m_mute     = '0;
    logic              m_ovr      = 1'b0;
    logic [15:0]       m_last_saw = '0;
    logic [15:0]       saw_q [$];
    smp_t              smp_q [$];

    // Stand-in converter: any deterministic, non-trivial map of the phase.
    function automatic logic [15:0] sin_fn(input logic [15:0] s);
        return {s[7:0], s[15:8]} ^ 16'hA5C3;
    endfunction

    logic [15:0] sin_q = '0;
    always @(posedge i_clk) sin_q <= sin_fn(o_saw);
    assign i_sin = sin_q;

    always #5 i_clk = ~i_clk;

    osc_bank_sched #(.VOICES(VOICES)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_addr (i_cfg_addr),
        .i_cfg_inc  (i_cfg_inc),
        .i_cfg_zero (i_cfg_zero),
        .o_saw      (o_saw),
        .i_sin      (i_sin),
        .o_sample   (o_sample),
        .o_voice    (o_voice),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
`ifdef OSC_SCHED_MUTE_EN
        .i_mute     (i_mute),
`endif
        .i_ovr_clr  (i_ovr_clr),
        .o_overrun  (o_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_phase[v] = '0;
            m_inc[v]   = '0;
        end
        m_ovr      = 1'b0;
        m_last_saw = '0;
        saw_q.delete();
        smp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_saw"},     32'(o_saw),     32'h0);
        check({tag, "_sample"},  32'(o_sample),  32'h0);
        check({tag, "_voice"},   32'(o_voice),   32'h0);
        check({tag, "_valid"},   32'(o_valid),   32'h0);
        check({tag, "_busy"},    32'(o_busy),    32'h0);
        check({tag, "_overrun"}, 32'(o_overrun), 32'h0);
    endtask

    task automatic cfg_write(input int a, input logic [15:0] inc_v, input logic zero);
        i_cfg_we   = 1'b1;
        i_cfg_addr = IW'(a);
        i_cfg_inc  = inc_v;
        i_cfg_zero = zero;
        step();
        i_cfg_we   = 1'b0;
        i_cfg_zero = 1'b0;
        m_inc[a] = inc_v;
        if (zero) m_phase[a] = '0;
    endtask

    // Idle cycles: no output activity, o_saw holds the last issued phase.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_valid", 32'(o_valid), 32'h0);
            check("idle_busy",  32'(o_busy),  32'h0);
            check("idle_saw",   32'(o_saw),   32'(m_last_saw));
            step();
        end
    endtask

    // One frame: tick now (cycle T), then check cycles T+1..T+VOICES+2.
    // wr_v >= 0 writes voice wr_v in its own issue cycle; xtick in 1..VOICES+2
    // drives a second (dropped) tick at T+xtick, optionally with i_ovr_clr.
    task automatic run_frame(input int wr_v, input logic [15:0] wr_inc, input logic wr_zero,
                             input int xtick, input logic xclr);
        logic [15:0] e;
        smp_t        s;
        check("pre_busy", 32'(o_busy), 32'h0);
        check("pre_ovr",  32'(o_overrun), 32'(m_ovr));
        i_tick = 1'b1;
        for (int v = 0; v < VOICES; v++) begin
            saw_q.push_back(m_phase[v]);
            smp_q.push_back('{voice: IW'(v), sample: (m_mute[v] ? 16'h0000 : sin_fn(m_phase[v]))});
            m_phase[v] = m_phase[v] + m_inc[v];
        end
        if (wr_v >= 0) begin
            m_inc[wr_v] = wr_inc;
            if (wr_zero) m_phase[wr_v] = '0;
        end
        step();
        i_tick = 1'b0;
        for (int c = 1; c <= VOICES + 2; c++) begin
            check("busy",    32'(o_busy),    32'h1);
            check("overrun", 32'(o_overrun), 32'(m_ovr));
            check("valid",   32'(o_valid),   32'(c >= 3));
            if (c <= VOICES) begin
                e = saw_q.pop_front();
                check("saw", 32'(o_saw), 32'(e));
                m_last_saw = e;
            end
            if (o_valid) begin
                if (smp_q.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'h0);
                end else begin
                    s = smp_q.pop_front();
                    check("voice",  32'(o_voice),  32'(s.voice));
                    check("sample", 32'(o_sample), 32'(s.sample));
                end
            end
            if (c - 1 == wr_v) begin
                i_cfg_we   = 1'b1;
                i_cfg_addr = IW'(wr_v);
                i_cfg_inc  = wr_inc;
                i_cfg_zero = wr_zero;
            end
            if (c == xtick) begin
                i_tick    = 1'b1;
                i_ovr_clr = xclr;
                m_ovr     = 1'b1;
            end
            step();
            i_tick     = 1'b0;
            i_ovr_clr  = 1'b0;
            i_cfg_we   = 1'b0;
            i_cfg_zero = 1'b0;
        end
        check("frame_drained", 32'(smp_q.size()), 32'h0);
    endtask

    initial begin
        model_reset();

        // Reset state.
        step();
        step();
        check_all_zero("reset");
        i_rst_n = 1'b1;
        step();

        cfg_write(0, 16'h0100, 1'b0);
        cfg_write(1, 16'h0200, 1'b0);
        cfg_write(2, 16'h4000, 1'b0);
        cfg_write(3, 16'hFFFF, 1'b0);

        // Frame 1 issues all zeros; frame 2 twenty cycles later issues the increments
        // and zeroes voice 2 in its own issue cycle (phase 4000).
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);
        idle(13);
        run_frame(2, 16'h4000, 1'b1, 0, 1'b0);

        // Back-to-back ticks at the minimum spacing; frame 3 shows voice 2 at 0
        // and voice 3 at FFFE, and rewrites voice 1's increment during its issue.
        run_frame(1, 16'h0300, 1'b0, 0, 1'b0);
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);

        // Overrun: tick at T+4 dropped, flag set at T+5.
        run_frame(-1, 16'h0000, 1'b0, 4, 1'b0);
        // Overrun tick with simultaneous clear keeps the flag set.
        run_frame(-1, 16'h0000, 1'b0, 2, 1'b1);
        idle(2);
        // A lone clear drops the flag.
        i_ovr_clr = 1'b1;
        step();
        i_ovr_clr = 1'b0;
        m_ovr = 1'b0;
        check("ovr_cleared", 32'(o_overrun), 32'h0);
        idle(2);

        // Reset at T+2 of a frame aborts it; outputs clear without waiting for a clock.
        check("pre_rst_busy", 32'(o_busy), 32'h0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        step();
        check("pre_rst_saw_nonzero", 32'(o_saw != 16'h0000), 32'h1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        step();
        i_rst_n = 1'b1;
        model_reset();
        idle(8);

        // Restart from voice 0 with phase 0.
        cfg_write(0, 16'h0123, 1'b0);
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);

`ifdef OSC_SCHED_MUTE_EN
        // Voice 1 muted: sample forced to 0, valid/voice intact, phase still advancing.
        cfg_write(1, 16'h0040, 1'b0);
        i_mute = 4'b0010;
        m_mute = 4'b0010;
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);
        i_mute = '0;
        m_mute = '0;
        run_frame(-1, 16'h0000, 1'b0, 0, 1'b0);
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
